// File: rtl/ssd_image_comparator.sv
// SSD engine: streams word windows from ImagemA/ImagemB in lockstep and accumulates the
// sum of squared byte differences, controlled through a small Avalon-MM register slave.
module ssd_image_comparator #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 14848,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctl_address,
  input  logic              ctl_chipselect,
  input  logic              ctl_write,
  input  logic              ctl_read,
  input  logic [31:0]       ctl_writedata,
  output logic [31:0]       ctl_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_a_address,
  output logic              mem_a_chipselect,
  input  logic [31:0]       mem_a_readdata,
  output logic [ADDR_W-1:0] mem_b_address,
  output logic              mem_b_chipselect,
  input  logic [31:0]       mem_b_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [16:0] LIMIT = 17'(DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       len_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic              cs_q;
  logic              drain_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              irq_en_q;
  logic              rd_valid_q;
  logic              sum_valid_q;
  logic [17:0]       lane_sum_q;
  logic [31:0]       readdata_q;

  logic              wr_ctrl_s;
  logic              wr_base_s;
  logic              wr_len_s;
  logic              start_s;
  logic              abort_s;
  logic [16:0]       end_s;
  logic [17:0]       lane_sum_d;
  logic [31:0]       readdata_d;
  logic              unused_wdata_s;

  // Four-lane sum of squared absolute byte differences; 255^2 fits in 16 bits.
  function automatic logic [17:0] lane_ssd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  diff;
    logic [15:0] sq;
    logic [17:0] sum;
    sum = 18'd0;
    for (int i = 0; i < 4; i++) begin
      if (a[8*i +: 8] >= b[8*i +: 8]) begin
        diff = a[8*i +: 8] - b[8*i +: 8];
      end else begin
        diff = b[8*i +: 8] - a[8*i +: 8];
      end
      sq  = 16'(diff) * 16'(diff);
      sum = sum + 18'(sq);
    end
    return sum;
  endfunction

  assign wr_ctrl_s      = ctl_chipselect & ctl_write & (ctl_address == 2'd0);
  assign wr_base_s      = ctl_chipselect & ctl_write & (ctl_address == 2'd1);
  assign wr_len_s       = ctl_chipselect & ctl_write & (ctl_address == 2'd2);
  assign start_s        = wr_ctrl_s & ctl_writedata[0];
  assign abort_s        = wr_ctrl_s & ctl_writedata[1];
  assign end_s          = 17'(base_q) + 17'(len_q);
  assign lane_sum_d     = lane_ssd(mem_a_readdata, mem_b_readdata);
  assign unused_wdata_s = ^ctl_writedata[31:16];

  // Register read mux.
  always_comb begin
    readdata_d = 32'd0;
    case (ctl_address)
      2'd0:    readdata_d = {28'd0, err_q, irq_en_q, done_q, busy_q};
      2'd1:    readdata_d = 32'(base_q);
      2'd2:    readdata_d = 32'(len_q);
      2'd3:    readdata_d = 32'(acc_q);
      default: readdata_d = 32'd0;
    endcase
  end

  // Control FSM, RAM address generator and SSD pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= 16'd0;
      acc_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= 16'd0;
      cs_q        <= 1'b0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      lane_sum_q  <= 18'd0;
      readdata_q  <= 32'd0;
    end else begin
      // Data for an address issued this cycle is on the RAM ports next cycle.
      rd_valid_q  <= (state_q == S_FETCH);
      sum_valid_q <= rd_valid_q;
      lane_sum_q  <= lane_sum_d;
      if (sum_valid_q) begin
        acc_q <= acc_q + ACC_W'(lane_sum_q);
      end

      if (ctl_chipselect && ctl_read) begin
        readdata_q <= readdata_d;
      end

      if (wr_ctrl_s) begin
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        irq_en_q <= ctl_writedata[2];
      end
      if (wr_base_s && (state_q == S_IDLE)) begin
        base_q <= ctl_writedata[ADDR_W-1:0];
      end
      if (wr_len_s && (state_q == S_IDLE)) begin
        len_q <= ctl_writedata[15:0];
      end

      case (state_q)
        S_IDLE: begin
          if (start_s && !abort_s) begin
            if (end_s > LIMIT) begin
              err_q <= 1'b1;
            end else if (len_q == 16'd0) begin
              done_q <= 1'b1;
              acc_q  <= '0;
            end else begin
              acc_q   <= '0;
              busy_q  <= 1'b1;
              addr_q  <= base_q;
              cnt_q   <= len_q;
              cs_q    <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (cnt_q == 16'd1) begin
            cs_q    <= 1'b0;
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - 16'd1;
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          cs_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase

      // Abort discards everything in flight, including the partial result.
      if (abort_s && (state_q != S_IDLE)) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        cs_q        <= 1'b0;
        done_q      <= 1'b0;
        acc_q       <= '0;
        rd_valid_q  <= 1'b0;
        sum_valid_q <= 1'b0;
      end
    end
  end

  assign ctl_readdata     = readdata_q;
  assign irq              = done_q & irq_en_q;
  assign mem_a_address    = addr_q;
  assign mem_b_address    = addr_q;
  assign mem_a_chipselect = cs_q;
  assign mem_b_chipselect = cs_q;

endmodule
